// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the ALU datapath: owns PC, IR and the NZP register,
// decodes ADD/AND/NOT/LEA/BR/HALT and resolves conditional branches from the ALU flags.
module control_unit #(
  parameter logic [5:0] RESET_PC = 6'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [5:0]  pc,
  output logic [1:0]  alu_op,
  output logic [1:0]  source_sel,
  output logic [5:0]  ins_immediate,
  output logic [2:0]  sr1_addr,
  output logic [2:0]  sr2_addr,
  output logic [2:0]  dr_addr,
  output logic        reg_we,
  input  logic        negative,
  input  logic        zero,
  input  logic        positive,
  output logic [2:0]  cc,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] SRC_IMM = 2'b00;
  localparam logic [1:0] SRC_PC  = 2'b01;
  localparam logic [1:0] SRC_REG = 2'b10;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src;
    logic [5:0] imm;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic [2:0] dr;
    logic       wr;
    logic       br;
    logic       halt;
    logic       ill;
  } dec_t;

  state_t      state, state_nx;
  logic [15:0] ir;
  logic [5:0]  pc_q;
  logic [2:0]  cc_q;
  logic        ill_q;
  dec_t        dec;
  logic        active;
  logic        br_taken;

  // Pure decode of the held instruction; gated onto the ports only in DECODE/EXECUTE.
  always_comb begin
    dec = '0;
    case (ir[15:12])
      OP_ADD, OP_AND, OP_NOT: begin
        dec.alu_op = (ir[15:12] == OP_AND) ? ALU_AND :
                     (ir[15:12] == OP_NOT) ? ALU_NOT : ALU_ADD;
        dec.src    = ir[5] ? SRC_IMM : SRC_REG;
        dec.imm    = {1'b0, ir[4:0]};
        dec.sr1    = ir[8:6];
        dec.sr2    = ir[2:0];
        dec.dr     = ir[11:9];
        dec.wr     = 1'b1;
      end
      OP_LEA: begin
        dec.alu_op = ALU_ADD;
        dec.src    = SRC_PC;
        dec.imm    = ir[5:0];
        dec.dr     = ir[11:9];
        dec.wr     = 1'b1;
      end
      OP_BR:   dec.br   = 1'b1;
      OP_HALT: dec.halt = 1'b1;
      default: dec.ill  = 1'b1;
    endcase
  end

  assign br_taken = dec.br && ((ir[11:9] & cc_q) != 3'b000);

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (imem_ack) state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC:   state_nx = (dec.halt || dec.ill) ? S_HALT : S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc_q  <= RESET_PC;
      cc_q  <= 3'b010;
      ir    <= 16'h0000;
      ill_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_FETCH: if (imem_ack) begin
          ir   <= imem_rdata;
          pc_q <= pc_q + 6'd1;
        end
        S_EXEC: begin
          if (dec.wr)   cc_q  <= {negative, zero, positive};
          // 6-bit add of the raw offset field is the sign-extended add mod 64.
          if (br_taken) pc_q  <= pc_q + ir[5:0];
          if (dec.ill)  ill_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign active        = (state == S_DECODE) || (state == S_EXEC);
  assign imem_req      = (state == S_FETCH);
  assign pc            = pc_q;
  assign cc            = cc_q;
  assign halted        = (state == S_HALT);
  assign illegal       = ill_q;
  assign alu_op        = active ? dec.alu_op : 2'b00;
  assign source_sel    = active ? dec.src    : 2'b00;
  assign ins_immediate = active ? dec.imm    : 6'd0;
  assign sr1_addr      = active ? dec.sr1    : 3'd0;
  assign sr2_addr      = active ? dec.sr2    : 3'd0;
  assign dr_addr       = active ? dec.dr     : 3'd0;
  // A reset landing on the execute cycle must suppress the register write.
  assign reg_we        = (state == S_EXEC) && dec.wr && !rst;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction reference model of PC/NZP/decode.
module tb_control_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [15:0] imem_rdata;
  logic [5:0]  pc, ins_immediate;
  logic [1:0]  alu_op, source_sel;
  logic [2:0]  sr1_addr, sr2_addr, dr_addr, cc;
  logic        reg_we, negative, zero, positive, halted, illegal;
  logic [18:0] obs;

  int n_pass = 0;
  int n_chk  = 0;

  // model state
  int         m_pc;
  logic [2:0] m_cc;
  logic       m_halted, m_ill;

  control_unit #(.RESET_PC(6'd0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .alu_op(alu_op), .source_sel(source_sel), .ins_immediate(ins_immediate),
    .sr1_addr(sr1_addr), .sr2_addr(sr2_addr), .dr_addr(dr_addr), .reg_we(reg_we),
    .negative(negative), .zero(zero), .positive(positive), .cc(cc),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;
  assign obs = {alu_op, source_sel, ins_immediate, sr1_addr, sr2_addr, dr_addr};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Expected decode bundle {alu_op, source_sel, imm, sr1, sr2, dr} from the encoding table.
  function automatic logic [18:0] exp_dec(input logic [15:0] ins);
    logic [1:0] a;
    case (ins[15:12])
      4'h1, 4'h5, 4'h9: begin
        a = (ins[15:12] == 4'h1) ? 2'd0 : (ins[15:12] == 4'h5) ? 2'd1 : 2'd2;
        return {a, (ins[5] ? 2'b00 : 2'b10), 1'b0, ins[4:0], ins[8:6], ins[2:0], ins[11:9]};
      end
      4'hE:    return {2'b00, 2'b01, ins[5:0], 3'd0, 3'd0, ins[11:9]};
      default: return 19'd0;
    endcase
  endfunction

  function automatic logic [2:0] rand_flags();
    case ($urandom_range(0, 2))
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_pc = 0; m_cc = 3'b010; m_halted = 1'b0; m_ill = 1'b0;
  endtask

  // Runs one instruction through FETCH (with wait states), DECODE and EXECUTE; entry at a FETCH negedge.
  task automatic run_instr(input logic [15:0] ins, input int waits, input logic [2:0] flg);
    logic [18:0] ed;
    logic        wr;
    int          off;
    ed = exp_dec(ins);
    wr = (ins[15:12] == 4'h1) || (ins[15:12] == 4'h5) || (ins[15:12] == 4'h9) || (ins[15:12] == 4'hE);
    for (int w = 0; w <= waits; w++) begin
      n_chk++;
      if ({imem_req, pc, reg_we, obs} !== {1'b1, m_pc[5:0], 1'b0, 19'd0}) begin
        $display("FAIL fetch ins=%h w=%0d: req=%b pc=%0d we=%b dec=%h, want req=1 pc=%0d we=0 dec=0",
                 ins, w, imem_req, pc, reg_we, obs, m_pc);
      end else n_pass++;
      imem_ack   = (w == waits);
      imem_rdata = (w == waits) ? ins : 16'($urandom);
      @(negedge clk);
    end
    m_pc = (m_pc + 1) % 64;
    imem_ack   = 1'($urandom);
    imem_rdata = 16'($urandom);
    n_chk++;
    if ({imem_req, pc, reg_we, obs} !== {1'b0, m_pc[5:0], 1'b0, ed}) begin
      $display("FAIL decode ins=%h: req=%b pc=%0d we=%b dec=%h, want req=0 pc=%0d we=0 dec=%h",
               ins, imem_req, pc, reg_we, obs, m_pc, ed);
    end else n_pass++;
    @(negedge clk);
    {negative, zero, positive} = flg;
    n_chk++;
    if ({imem_req, pc, reg_we, obs} !== {1'b0, m_pc[5:0], wr, ed}) begin
      $display("FAIL execute ins=%h: req=%b pc=%0d we=%b dec=%h, want req=0 pc=%0d we=%b dec=%h",
               ins, imem_req, pc, reg_we, obs, m_pc, wr, ed);
    end else n_pass++;
    @(negedge clk);
    imem_ack = 1'b0;
    if (wr) m_cc = flg;
    else if (ins[15:12] == 4'h0) begin
      off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
      if ((ins[11:9] & m_cc) != 3'b000) m_pc = ((m_pc + off) % 64 + 64) % 64;
    end else if (ins[15:12] == 4'hF) m_halted = 1'b1;
    else begin m_halted = 1'b1; m_ill = 1'b1; end
    n_chk++;
    if ({pc, cc, halted, illegal, imem_req} !== {m_pc[5:0], m_cc, m_halted, m_ill, ~m_halted}) begin
      $display("FAIL retire ins=%h: pc=%0d cc=%b halt=%b ill=%b req=%b, want pc=%0d cc=%b halt=%b ill=%b",
               ins, pc, cc, halted, illegal, imem_req, m_pc, m_cc, m_halted, m_ill);
    end else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({pc, cc, reg_we, halted, illegal, imem_req, obs} !== {6'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 19'd0}) begin
      $display("FAIL reset: pc=%0d cc=%b we=%b halt=%b ill=%b req=%b dec=%h, want pc=0 cc=010 we=0 halt=0 ill=0 req=1 dec=0",
               pc, cc, reg_we, halted, illegal, imem_req, obs);
    end else n_pass++;
  endtask

  task automatic test_add_imm();
    do_reset();
    run_instr(16'h1265, 0, 3'b001);
    n_chk++;
    if ({pc, cc} !== {6'd1, 3'b001}) begin
      $display("FAIL add_imm: pc=%0d cc=%b, want pc=1 cc=001", pc, cc);
    end else n_pass++;
  endtask

  task automatic test_wait_states();
    do_reset();
    run_instr(16'h5A83, 4, 3'b100);  // AND R5,R2,R3 register form
    run_instr(16'h9E7F, 2, 3'b001);  // NOT immediate form
  endtask

  task automatic test_branch();
    do_reset();
    repeat (5) run_instr(16'h1265, 0, 3'b010);
    run_instr(16'h05FD, 0, 3'b100);  // BRz -3, taken
    n_chk++;
    if (pc !== 6'd3) $display("FAIL brz_taken: pc=%0d, want 3", pc); else n_pass++;
    repeat (2) run_instr(16'h1265, 0, 3'b010);
    run_instr(16'h09FD, 1, 3'b001);  // BRn -3, not taken
    n_chk++;
    if (pc !== 6'd6) $display("FAIL brn_not_taken: pc=%0d, want 6", pc); else n_pass++;
    do_reset();
    repeat (5) run_instr(16'h1265, 0, 3'b010);
    run_instr(16'h01FD, 0, 3'b001);  // nzp=000 NOP
    n_chk++;
    if ({pc, cc} !== {6'd6, 3'b010}) $display("FAIL br_nop: pc=%0d cc=%b, want pc=6 cc=010", pc, cc); else n_pass++;
  endtask

  task automatic test_pc_wrap();
    do_reset();
    run_instr(16'h0FFE, 0, 3'b010);  // BRnzp -2 from pc 1 -> 63
    n_chk++;
    if (pc !== 6'd63) $display("FAIL wrap_br: pc=%0d, want 63", pc); else n_pass++;
    run_instr(16'h1265, 0, 3'b100);
    n_chk++;
    if (pc !== 6'd0) $display("FAIL wrap_add: pc=%0d, want 0", pc); else n_pass++;
    run_instr(16'h0FFE, 0, 3'b001);
    run_instr(16'hE202, 0, 3'b001);  // LEA R1, +2 at pc 63
    n_chk++;
    if (pc !== 6'd0) $display("FAIL wrap_lea: pc=%0d, want 0", pc); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0]  ops [5] = '{4'h1, 4'h5, 4'h9, 4'hE, 4'h0};
    logic [15:0] ins;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      ins = {ops[$urandom_range(0, 4)], 12'($urandom)};
      run_instr(ins, $urandom_range(0, 3), rand_flags());
    end
  endtask

  task automatic test_halt();
    logic [5:0] hold_pc;
    do_reset();
    run_instr(16'h1265, 0, 3'b001);
    run_instr(16'hF000, 1, 3'b100);
    hold_pc = m_pc[5:0];
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom); imem_rdata = 16'h1265;
      @(negedge clk);
      n_chk++;
      if ({imem_req, halted, reg_we, pc} !== {1'b0, 1'b1, 1'b0, hold_pc}) begin
        $display("FAIL halt_hold c=%0d: req=%b halt=%b we=%b pc=%0d, want req=0 halt=1 we=0 pc=%0d",
                 i, imem_req, halted, reg_we, pc, hold_pc);
      end else n_pass++;
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr(16'h3ABC, 0, 3'b001);
    repeat (5) @(negedge clk);
    n_chk++;
    if ({illegal, halted, imem_req, cc} !== {1'b1, 1'b1, 1'b0, 3'b010}) begin
      $display("FAIL illegal_sticky: ill=%b halt=%b req=%b cc=%b, want ill=1 halt=1 req=0 cc=010",
               illegal, halted, imem_req, cc);
    end else n_pass++;
    do_reset();
    n_chk++;
    if ({illegal, halted, imem_req} !== 3'b001) begin
      $display("FAIL illegal_clear: ill=%b halt=%b req=%b, want ill=0 halt=0 req=1", illegal, halted, imem_req);
    end else n_pass++;
  endtask

  task automatic test_reset_abort();
    do_reset();
    run_instr(16'h1265, 0, 3'b100);
    imem_ack = 1'b1; imem_rdata = 16'h1265;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);  // execute cycle
    {negative, zero, positive} = 3'b001;
    rst = 1'b1;
    #1;
    n_chk++;
    if (reg_we !== 1'b0) $display("FAIL rst_exec_we: we=%b, want 0", reg_we); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({pc, cc, imem_req, reg_we} !== {6'd0, 3'b010, 1'b1, 1'b0}) begin
      $display("FAIL rst_exec_state: pc=%0d cc=%b req=%b we=%b, want pc=0 cc=010 req=1 we=0", pc, cc, imem_req, reg_we);
    end else n_pass++;
    // reset together with a fetch ack: the word must not be taken
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h1265;
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({pc, imem_req, reg_we, obs} !== {6'd0, 1'b1, 1'b0, 19'd0}) begin
      $display("FAIL rst_fetch: pc=%0d req=%b we=%b dec=%h, want pc=0 req=1 we=0 dec=0", pc, imem_req, reg_we, obs);
    end else n_pass++;
    m_pc = 0; m_cc = 3'b010; m_halted = 1'b0; m_ill = 1'b0;
    run_instr(16'h5042, 0, 3'b100);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0000;
    {negative, zero, positive} = 3'b010;
    test_reset();
    test_add_imm();
    test_wait_states();
    test_branch();
    test_pc_wrap();
    test_halt();
    test_illegal();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
